// File: rtl/fifo_axis_reader_pkg.sv
// Shared helpers for the FIFO and its AXI-Stream reader: counter sizing and
// the occupancy type of the 2-entry output buffer.
package fifo_axis_reader_pkg;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // A packet counter needs at least one bit even when PKT_LEN is 1.
  function automatic int cnt_width(input int pkt_len);
    return (clogb2(pkt_len) < 1) ? 1 : clogb2(pkt_len);
  endfunction

endpackage

// File: rtl/fifo_axis_reader_skid.sv
// 2-entry register buffer: word written via wr_en/wr_data, presented on a
// registered valid/ready port with the oldest entry at the head.
module axis_skid_buf2
  import fifo_axis_reader_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output occ_t             occ
);

  logic [WIDTH-1:0] d0_r, d1_r, d0_s, d1_s;
  occ_t             occ_r, occ_s;
  logic             valid_r;
  logic             pop_s;

  assign pop_s = valid_r && ready;

  // Next buffer contents: a simultaneous write and pop keeps occ and queues
  // the new word behind whatever remains.
  always_comb begin
    d0_s  = d0_r;
    d1_s  = d1_r;
    occ_s = occ_r;
    case ({wr_en, pop_s})
      2'b10: begin
        if (occ_r == OCC_EMPTY) begin
          d0_s = wr_data;
        end else begin
          d1_s = wr_data;
        end
        occ_s = occ_r + 2'd1;
      end
      2'b01: begin
        d0_s  = d1_r;
        occ_s = occ_r - 2'd1;
      end
      2'b11: begin
        if (occ_r == OCC_ONE) begin
          d0_s = wr_data;
        end else begin
          d0_s = d1_r;
          d1_s = wr_data;
        end
      end
      default: begin
        occ_s = occ_r;
      end
    endcase
  end

  // Buffer registers; valid is its own flop so the stream side sees a pure register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0_r    <= '0;
      d1_r    <= '0;
      occ_r   <= OCC_EMPTY;
      valid_r <= 1'b0;
    end else begin
      d0_r    <= d0_s;
      d1_r    <= d1_s;
      occ_r   <= occ_s;
      valid_r <= (occ_s != OCC_EMPTY);
    end
  end

  assign valid = valid_r;
  assign data  = d0_r;
  assign occ   = occ_r;

endmodule

// File: rtl/fifo_axis_reader.sv
// Pops a standard synchronous FIFO and re-times its data into an AXI-Stream
// master with tlast every PKT_LEN beats, at up to one beat per clock.
module fifo_axis_reader
  import fifo_axis_reader_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int PKT_LEN = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             pkt_done,
  output logic             busy
);

  localparam int               CNT_W     = cnt_width(PKT_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

  logic             infl_r;
  logic             pkt_done_r;
  logic [CNT_W-1:0] beat_cnt_r;
  occ_t             occ_s;
  logic             pop_s;
  logic [2:0]       credit_s;

  assign pop_s    = m_tvalid && m_tready;
  // Entries the buffer will hold next cycle; a read is safe while this is below 2.
  assign credit_s = 3'(occ_s) + 3'(infl_r) - 3'(pop_s);

  assign fifo_rd_en = !rst && !fifo_empty && (credit_s < 3'd2);

  axis_skid_buf2 #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (infl_r),
    .wr_data (fifo_dout),
    .valid   (m_tvalid),
    .ready   (m_tready),
    .data    (m_tdata),
    .occ     (occ_s)
  );

  assign m_tlast  = m_tvalid && (beat_cnt_r == LAST_BEAT);
  assign pkt_done = pkt_done_r;
  assign busy     = (occ_s != OCC_EMPTY) || infl_r;

  // In-flight flag: fifo_dout carries a fresh word the cycle after a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_r <= 1'b0;
    end else begin
      infl_r <= fifo_rd_en;
    end
  end

  // Beat counter advances only on handshakes, so it holds across FIFO starvation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_r <= '0;
    end else if (pop_s) begin
      if (beat_cnt_r == LAST_BEAT) begin
        beat_cnt_r <= '0;
      end else begin
        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      end
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  // End-of-packet pulse, one clock after the tlast handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_done_r <= 1'b0;
    end else begin
      pkt_done_r <= pop_s && m_tlast;
    end
  end

endmodule
